// File: rtl/adc128s_spi_model.sv
// Bench-side model of an 8-channel 12-bit SPI ADC (ADC128S-style): SPI mode 3, 16-bit frames, one-frame latency.
// Define ADC_MISO_TRISTATE_EN to float MISO while deselected or in reset; otherwise MISO is driven 0 there.
module adc128s_spi_model #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [2:0]  CH_LFT       = 3'd0,
    parameter logic [2:0]  CH_RGHT      = 3'd4,
    parameter logic [2:0]  CH_STEER     = 3'd5,
    parameter logic [2:0]  CH_BATT      = 3'd6,
    parameter logic [11:0] UNMAPPED_VAL = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_d, sclk_d;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall, in_frame;

    logic [15:0] tx;
    logic [15:0] rx;
    logic [4:0]  cnt;
    logic [2:0]  chnl_addr;
    logic        miso_q;
    logic [11:0] sel_val;
    logic [15:0] snap;
    logic        unused_rx;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    // SCLK edges only count once SS_n has been low for a full synced cycle
    assign in_frame  = ~ss_d & ~ss_s;
    assign sclk_rise = in_frame & ~sclk_d & sclk_s;
    assign sclk_fall = in_frame & sclk_d & ~sclk_s;

    always_comb begin
        sel_val = UNMAPPED_VAL;
        if (chnl_addr == CH_LFT)
            sel_val = ld_cell_lft;
        else if (chnl_addr == CH_RGHT)
            sel_val = ld_cell_rght;
        else if (chnl_addr == CH_STEER)
            sel_val = steerPot;
        else if (chnl_addr == CH_BATT)
            sel_val = batt;
    end

    assign snap      = {4'b0000, sel_val};
    assign unused_rx = ^{rx[15:14], rx[10:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b1;
            tx        <= '0;
            rx        <= '0;
            cnt       <= '0;
            chnl_addr <= '0;
            miso_q    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;

            if (ss_fall) begin
                tx     <= snap;
                miso_q <= snap[15];
                rx     <= '0;
                cnt    <= '0;
            end else if (ss_rise) begin
                if (cnt == 5'd16)
                    chnl_addr <= rx[13:11];
                miso_q <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    if (cnt < 5'd16)
                        rx <= {rx[14:0], mosi_s};
                    if (cnt < 5'd17)
                        cnt <= cnt + 5'd1;
                end
                // The fall that precedes the first rise must not consume the MSB
                if (sclk_fall && cnt != 5'd0) begin
                    tx     <= {tx[14:0], 1'b0};
                    miso_q <= (cnt > 5'd16) ? 1'b0 : tx[14];
                end
            end
        end
    end

`ifdef ADC_MISO_TRISTATE_EN
    assign MISO = (rst || ss_s) ? 1'bz : miso_q;
`else
    assign MISO = ss_s ? 1'b0 : miso_q;
`endif

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Randomized self-checking bench for adc128s_spi_model against a frame-level reference model.
module tb_adc128s_spi_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] ld_cell_lft;
    logic [11:0] ld_cell_rght;
    logic [11:0] steerPot;
    logic [11:0] batt;

    int          checks = 0;
    int          errors = 0;
    int          model_addr;
    logic        idle_exp;
    logic [31:0] w;

    adc128s_spi_model dut (
        .clk         (clk),
        .rst         (rst),
        .SS_n        (SS_n),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .ld_cell_lft (ld_cell_lft),
        .ld_cell_rght(ld_cell_rght),
        .steerPot    (steerPot),
        .batt        (batt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] chan_val(input int a);
        case (a)
            0:       return ld_cell_lft;
            4:       return ld_cell_rght;
            5:       return steerPot;
            6:       return batt;
            default: return 12'h000;
        endcase
    endfunction

    task automatic rand_inputs();
        ld_cell_lft  = 12'($urandom);
        ld_cell_rght = 12'($urandom);
        steerPot     = 12'($urandom);
        batt         = 12'($urandom);
    endtask

    // mid: 0 none, 1 randomize all inputs mid-frame, 2 steerPot <= 12'h800 mid-frame
    task automatic frame(input logic [15:0] cmd, input int nbits, input int mid,
                         input int gap, output logic [31:0] got);
        logic [31:0] exp;
        logic [31:0] mask;
        exp  = {4'h0, chan_val(model_addr), 16'h0000};
        mask = 32'hFFFF_FFFF << (32 - nbits);
        got  = '0;
        SS_n = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            if (i < 16) MOSI = cmd[15-i];
            else        MOSI = 1'($urandom);
            tick(6);
            if (i == 8 && mid == 1) rand_inputs();
            if (i == 8 && mid == 2) steerPot = 12'h800;
            got[31-i] = MISO;
            SCLK = 1'b1;
            tick(6);
        end
        SS_n = 1'b1;
        check("frame_word", got, exp & mask);
        if (nbits == 16) model_addr = int'(cmd[13:11]);
        if (gap >= 4) begin
            tick(4);
            check("idle_miso", {31'h0, MISO}, {31'h0, idle_exp});
            tick(gap - 4);
        end else begin
            tick(gap);
        end
    endtask

    initial begin
`ifdef ADC_MISO_TRISTATE_EN
        idle_exp = 1'bz;
`else
        idle_exp = 1'b0;
`endif
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        ld_cell_lft = 12'h300; ld_cell_rght = 12'h300; steerPot = 12'h123; batt = 12'h3A0;
        tick(3);
        check("reset_miso", {31'h0, MISO}, {31'h0, idle_exp});
        rst = 1'b0;
        model_addr = 0;
        tick(2);

        frame(16'h2000, 16, 0, 6, w);
        check("t1_first_lft", {16'h0, w[31:16]}, 32'h0000_0300);
        frame(16'h3000, 16, 0, 6, w);
        check("t2_ch4", {16'h0, w[31:16]}, 32'h0000_0300);
        frame(16'h3000, 16, 0, 6, w);
        check("t3_ch6", {16'h0, w[31:16]}, 32'h0000_03A0);
        batt = 12'h900;
        steerPot = 12'hE00;
        frame(16'h2800, 16, 0, 6, w);
        check("t3_ch6_upd", {16'h0, w[31:16]}, 32'h0000_0900);
        frame(16'h1000, 16, 0, 6, w);
        check("t4_ch5", {16'h0, w[31:16]}, 32'h0000_0E00);
        frame(16'h2800, 16, 0, 6, w);
        check("t4_unmapped", {16'h0, w[31:16]}, 32'h0000_0000);
        steerPot = 12'h200;
        frame(16'h3000, 8, 0, 6, w);
        check("t5_short", {24'h0, w[31:24]}, 32'h0000_0002);
        frame(16'h2800, 16, 2, 6, w);
        check("t6_mid_chg", {16'h0, w[31:16]}, 32'h0000_0200);
        frame(16'h0000, 16, 0, 1, w);
        check("t6_next", {16'h0, w[31:16]}, 32'h0000_0800);

        // reset in the middle of a frame abandons it and returns to channel 0
        frame(16'h3000, 16, 0, 6, w);
        SS_n = 1'b0;
        tick(6);
        repeat (3) begin
            SCLK = 1'b0; MOSI = 1'b1; tick(6);
            SCLK = 1'b1; tick(6);
        end
        rst = 1'b1;
        tick(3);
        check("midrst_miso", {31'h0, MISO}, {31'h0, idle_exp});
        rst = 1'b0; SS_n = 1'b1;
        tick(6);
        model_addr = 0;
        frame(16'h2800, 16, 0, 6, w);
        check("midrst_lft", {16'h0, w[31:16]}, {20'h0, ld_cell_lft});

        for (int k = 0; k < 60; k++) begin
            int r;
            int nb;
            if ($urandom_range(0, 2) == 0) rand_inputs();
            if ($urandom_range(0, 4) == 0) begin
                for (int j = 0; j < 3; j++) begin
                    SCLK = 1'b0; MOSI = 1'($urandom); tick(6);
                    SCLK = 1'b1; tick(6);
                end
            end
            r = $urandom_range(0, 9);
            if (r == 0)      nb = $urandom_range(1, 15);
            else if (r == 1) nb = $urandom_range(17, 24);
            else             nb = 16;
            frame(16'($urandom), nb, ($urandom_range(0, 3) == 0) ? 1 : 0,
                  $urandom_range(1, 8), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
